// File: rtl/regstrb_inst_assembler_if.sv
// regstrb_inst_assembler_if: register-word inputs and code-memory write bus of the instruction assembler
interface regstrb_inst_assembler_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_INST = 2,
  parameter int ADDR_WIDTH     = 10
);
  logic [WORDS_PER_INST*WORD_WIDTH-1:0] word_value;
  logic [WORDS_PER_INST-1:0]            word_strobe;
  logic                                 control_start;
  logic [ADDR_WIDTH-1:0]                mem_wr_addr;
  logic [WORDS_PER_INST*WORD_WIDTH-1:0] mem_wr_data;
  logic                                 mem_wr_en;
  logic                                 mem_wr_ready;
  logic [ADDR_WIDTH:0]                  inst_count;
  logic                                 overflow;
  logic                                 addr_wrap;
  modport master (
    input  word_value, word_strobe, control_start, mem_wr_ready,
    output mem_wr_addr, mem_wr_data, mem_wr_en, inst_count, overflow, addr_wrap
  );
  modport slave (
    output word_value, word_strobe, control_start, mem_wr_ready,
    input  mem_wr_addr, mem_wr_data, mem_wr_en, inst_count, overflow, addr_wrap
  );
endinterface

// File: rtl/regstrb_inst_assembler.sv
// regstrb_inst_assembler: gathers strobed register words into instructions and streams them to code memory via a FIFO
// Optional REGSTRB_DUP_ERR_EN adds a sticky dup_err output and discards partials hit by a repeated strobe.
module regstrb_inst_assembler #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_INST = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  regstrb_inst_assembler_if.master bus
`ifdef REGSTRB_DUP_ERR_EN
  ,
  output logic dup_err
`endif
);
  localparam int DW = WORDS_PER_INST*WORD_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DW-1:0]             stage_q, stage_d, merged;
  logic [WORDS_PER_INST-1:0] valid_q, valid_d, eff_strb;
  logic [DW-1:0]             fifo_q [FIFO_DEPTH];
  logic [DW-1:0]             fifo_d [FIFO_DEPTH];
  logic [PW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH:0]       cnt_q, cnt_d;
  logic                      ovf_q, ovf_d, wrap_q, wrap_d, dup_q, dup_d;
  logic                      complete, dup, full, empty, push, pop;
  always_comb begin
    eff_strb = bus.control_start ? '0 : bus.word_strobe;
    merged = stage_q;
    for (int i = 0; i < WORDS_PER_INST; i++)
      if (eff_strb[i]) merged[i*WORD_WIDTH +: WORD_WIDTH] = bus.word_value[i*WORD_WIDTH +: WORD_WIDTH];
    complete = !bus.control_start && &(valid_q | eff_strb);
`ifdef REGSTRB_DUP_ERR_EN
    dup = |(valid_q & eff_strb) && !complete;
`else
    dup = 1'b0;
`endif
    full = (wr_ptr_q - rd_ptr_q) == (PW+1)'(FIFO_DEPTH);
    empty = wr_ptr_q == rd_ptr_q;
    push = complete && !full;
    pop = bus.mem_wr_en && bus.mem_wr_ready;
    stage_d = merged;
    valid_d = (bus.control_start || complete || dup) ? '0 : valid_q | eff_strb;
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q[PW-1:0]] = merged;
    wr_ptr_d = bus.control_start ? '0 : wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = bus.control_start ? '0 : rd_ptr_q + (PW+1)'(pop);
    addr_d = bus.control_start ? '0 : addr_q + ADDR_WIDTH'(pop);
    // the count saturates at 2^ADDR_WIDTH, i.e. once its MSB is set
    cnt_d = bus.control_start ? '0 : cnt_q + (ADDR_WIDTH+1)'(pop && !cnt_q[ADDR_WIDTH]);
    ovf_d = ovf_q | (complete && full);
    wrap_d = wrap_q | (pop && &addr_q);
    dup_d = dup_q | dup;
  end
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    fifo_q <= fifo_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      wrap_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      wrap_q <= wrap_d;
      dup_q <= dup_d;
    end
  end
  assign bus.mem_wr_en = !empty && !bus.control_start;
  assign bus.mem_wr_data = fifo_q[rd_ptr_q[PW-1:0]];
  assign bus.mem_wr_addr = addr_q;
  assign bus.inst_count = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.addr_wrap = wrap_q;
`ifdef REGSTRB_DUP_ERR_EN
  assign dup_err = dup_q;
`else
  logic unused_dup;
  assign unused_dup = dup_q;
`endif
endmodule

// File: tb/tb_regstrb_inst_assembler.sv
// tb_regstrb_inst_assembler: scoreboard bench for regstrb_inst_assembler (default and 2-bit address instances)
module tb_regstrb_inst_assembler;
  typedef struct {
    logic [9:0]  addr;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regstrb_inst_assembler_if #(.WORD_WIDTH(32), .WORDS_PER_INST(2), .ADDR_WIDTH(10)) ia();
  regstrb_inst_assembler_if #(.WORD_WIDTH(32), .WORDS_PER_INST(2), .ADDR_WIDTH(2)) ib();
`ifdef REGSTRB_DUP_ERR_EN
  logic dup_a, dup_b;
`endif
  regstrb_inst_assembler #(.WORD_WIDTH(32), .WORDS_PER_INST(2), .ADDR_WIDTH(10), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
`ifdef REGSTRB_DUP_ERR_EN
    , .dup_err(dup_a)
`endif
  );
  regstrb_inst_assembler #(.WORD_WIDTH(32), .WORDS_PER_INST(2), .ADDR_WIDTH(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
`ifdef REGSTRB_DUP_ERR_EN
    , .dup_err(dup_b)
`endif
  );
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [9:0] next_a;
  logic [1:0] next_b;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [63:0] d);
    qa.push_back('{next_a, d});
    next_a = next_a + 10'd1;
  endtask
  task automatic push_b(input logic [63:0] d);
    qb.push_back('{{8'd0, next_b}, d});
    next_b = next_b + 2'd1;
  endtask
  task automatic drive_a(input logic [1:0] s, input logic [63:0] v);
    ia.word_strobe = s;
    ia.word_value = v;
    tick();
    ia.word_strobe = '0;
    ia.word_value = {$urandom, $urandom};
  endtask
  task automatic drive_b(input logic [1:0] s, input logic [63:0] v);
    ib.word_strobe = s;
    ib.word_value = v;
    tick();
    ib.word_strobe = '0;
    ib.word_value = {$urandom, $urandom};
  endtask
  task automatic pulse_cs_a();
    ia.control_start = 1'b1;
    tick();
    ia.control_start = 1'b0;
    next_a = '0;
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_left", 64'(qa.size() + qb.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && ia.mem_wr_en && ia.mem_wr_ready) begin
      if (qa.size() == 0) chk("a_unexpected_wr", {54'd0, ia.mem_wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        ea = qa.pop_front();
        chk("a_addr", 64'(ia.mem_wr_addr), 64'(ea.addr));
        chk("a_data", ia.mem_wr_data, ea.data);
      end
    end
    if (!rst && ib.mem_wr_en && ib.mem_wr_ready) begin
      if (qb.size() == 0) chk("b_unexpected_wr", {62'd0, ib.mem_wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        eb = qb.pop_front();
        chk("b_addr", 64'(ib.mem_wr_addr), 64'(eb.addr));
        chk("b_data", ib.mem_wr_data, eb.data);
      end
    end
  end
  initial begin
    ia.word_value = '0; ia.word_strobe = '0; ia.control_start = 1'b0; ia.mem_wr_ready = 1'b1;
    ib.word_value = '0; ib.word_strobe = '0; ib.control_start = 1'b0; ib.mem_wr_ready = 1'b1;
    next_a = '0;
    next_b = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en", 64'(ia.mem_wr_en), 64'd0);
    chk("rst_addr", 64'(ia.mem_wr_addr), 64'd0);
    chk("rst_cnt", 64'(ia.inst_count), 64'd0);
    chk("rst_ovf", 64'(ia.overflow), 64'd0);
    chk("rst_wrap", 64'(ia.addr_wrap), 64'd0);
`ifdef REGSTRB_DUP_ERR_EN
    chk("rst_dup", 64'(dup_a), 64'd0);
`endif
    // separate strobes, two instructions
    drive_a(2'b01, 64'h0000_0000_1111_1111);
    tick();
    tick();
    push_a(64'h2222_2222_1111_1111);
    drive_a(2'b10, 64'h2222_2222_0000_0000);
    chk("lat_en", 64'(ia.mem_wr_en), 64'd1);
    chk("lat_addr", 64'(ia.mem_wr_addr), 64'd0);
    drive_a(2'b10, 64'h4444_4444_0000_0000);
    push_a(64'h4444_4444_3333_3333);
    drive_a(2'b01, 64'h0000_0000_3333_3333);
    drain();
    chk("pair_cnt", 64'(ia.inst_count), 64'd2);
    chk("pair_addr", 64'(ia.mem_wr_addr), 64'd2);
    // simultaneous strobes, value changes afterwards
    pulse_cs_a();
    push_a(64'h0000_000B_0000_000A);
    drive_a(2'b11, 64'h0000_000B_0000_000A);
    drain();
    chk("both_cnt", 64'(ia.inst_count), 64'd1);
    // backpressure and overflow
    pulse_cs_a();
    ia.mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_a({32'(i + 100), 32'(i)});
      drive_a(2'b11, {32'(i + 100), 32'(i)});
    end
    chk("ovf_set", 64'(ia.overflow), 64'd1);
    chk("ovf_en", 64'(ia.mem_wr_en), 64'd1);
    chk("ovf_cnt0", 64'(ia.inst_count), 64'd0);
    ia.mem_wr_ready = 1'b1;
    drain();
    chk("ovf_cnt4", 64'(ia.inst_count), 64'd4);
    // control_start discards a partial instruction
    pulse_cs_a();
    drive_a(2'b01, 64'h0000_0000_DEAD_0000);
    pulse_cs_a();
    drive_a(2'b10, 64'hBEEF_0000_0000_0000);
    tick();
    tick();
    chk("cs_nowr", 64'(ia.mem_wr_en), 64'd0);
    push_a(64'h0000_0C0C_0000_0B0B);
    drive_a(2'b11, 64'h0000_0C0C_0000_0B0B);
    drain();
    // control_start flushes a FIFO holding two entries
    ia.mem_wr_ready = 1'b0;
    drive_a(2'b11, 64'h1);
    drive_a(2'b11, 64'h2);
    chk("flush_pre_en", 64'(ia.mem_wr_en), 64'd1);
    pulse_cs_a();
    chk("flush_en", 64'(ia.mem_wr_en), 64'd0);
    chk("flush_cnt", 64'(ia.inst_count), 64'd0);
    chk("flush_addr", 64'(ia.mem_wr_addr), 64'd0);
    ia.mem_wr_ready = 1'b1;
    tick();
    chk("flush_en2", 64'(ia.mem_wr_en), 64'd0);
    chk("flush_ovf_kept", 64'(ia.overflow), 64'd1);
    // repeated strobe on a pending word
    pulse_cs_a();
`ifdef REGSTRB_DUP_ERR_EN
    drive_a(2'b01, 64'h55);
    drive_a(2'b01, 64'h66);
    chk("dup_set", 64'(dup_a), 64'd1);
    drive_a(2'b10, 64'h0000_0077_0000_0000);
    tick();
    tick();
    chk("dup_nowr", 64'(ia.mem_wr_en), 64'd0);
    push_a(64'h0000_0099_0000_0088);
    drive_a(2'b11, 64'h0000_0099_0000_0088);
    drain();
    chk("dup_sticky", 64'(dup_a), 64'd1);
`else
    drive_a(2'b01, 64'h55);
    drive_a(2'b01, 64'h66);
    push_a(64'h0000_0077_0000_0066);
    drive_a(2'b10, 64'h0000_0077_0000_0000);
    drain();
`endif
    chk("dup_cnt", 64'(ia.inst_count), 64'd1);
    // 2-bit address instance: wrap and saturation
    for (int i = 0; i < 3; i++) begin
      push_b({32'hB0 + 32'(i), 32'(i)});
      drive_b(2'b11, {32'hB0 + 32'(i), 32'(i)});
    end
    drain();
    chk("b_wrap0", 64'(ib.addr_wrap), 64'd0);
    chk("b_cnt3", 64'(ib.inst_count), 64'd3);
    for (int i = 3; i < 5; i++) begin
      push_b({32'hB0 + 32'(i), 32'(i)});
      drive_b(2'b11, {32'hB0 + 32'(i), 32'(i)});
    end
    drain();
    chk("b_wrap1", 64'(ib.addr_wrap), 64'd1);
    chk("b_cnt_sat", 64'(ib.inst_count), 64'd4);
    chk("b_addr_end", 64'(ib.mem_wr_addr), 64'd1);
    // reset mid-operation drops buffered work and clears sticky flags
    ia.mem_wr_ready = 1'b0;
    drive_a(2'b11, 64'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.mem_wr_ready = 1'b1;
    chk("mid_rst_en", 64'(ia.mem_wr_en), 64'd0);
    chk("mid_rst_ovf", 64'(ia.overflow), 64'd0);
    chk("mid_rst_wrap", 64'(ib.addr_wrap), 64'd0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regstrb_inst_assembler.md
Name: regstrb_inst_assembler

Overview:
- Parametrised successor to the register-strobe-to-code-memory converter.
- Collects WORDS_PER_INST register words, each qualified by its own strobe, into one instruction word and writes it to code memory at sequential addresses.
- Each word is latched on its strobe, so register values may change after they are strobed.
- Completed instructions pass through a small FIFO, so code memory may apply backpressure; strobes may arrive in any order and may coincide.
- Sits between the AXI-Lite register block and the packet filter code memory.

Parameters:
WORD_WIDTH, 32, width of one register word
WORDS_PER_INST, 2, register words per instruction (>=1); word 0 is least significant
ADDR_WIDTH, 10, code memory address width
FIFO_DEPTH, 4, completed-instruction buffer depth (power of 2, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
word_value  in  WORDS_PER_INST*WORD_WIDTH  word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
word_strobe  in  WORDS_PER_INST  bit i: word i written this cycle
control_start  in  1  filter running; while high, programming is inhibited and state is cleared
mem_wr_addr  out  ADDR_WIDTH  code memory write address
mem_wr_data  out  WORDS_PER_INST*WORD_WIDTH  instruction data
mem_wr_en  out  1  write request
mem_wr_ready  in  1  memory accepts the write this cycle (tie high if unused)
inst_count  out  ADDR_WIDTH+1  accepted writes since start/reset, saturating at 2^ADDR_WIDTH
overflow  out  1  sticky: an instruction was dropped because the FIFO was full
addr_wrap  out  1  sticky: write address wrapped past 2^ADDR_WIDTH-1

Behaviour:
- Reset (rst=1 at edge): staging valids=0, FIFO empty, mem_wr_addr=0, mem_wr_en=0, inst_count=0, overflow=0, addr_wrap=0. mem_wr_data is don't-care while mem_wr_en=0.
- Staging: per-word register and valid bit. When word_strobe[i]=1 and control_start=0, stage[i]<=word_value slice i and valid[i]<=1.
  - A strobe on an already-valid word overwrites it; the latest value wins.
- Completion: complete = AND over i of (valid[i] | word_strobe[i]), with control_start=0.
  - Same cycle: push {stage with strobed slices replaced by current word_value} into the FIFO and clear all valids.
  - Any mix of simultaneous strobes is legal. All strobes high in one cycle completes the instruction directly.
- FIFO full on completion: the instruction is dropped, overflow<=1, valids are still cleared. A pop in the same cycle does not free space for that push.
- Output: mem_wr_en = FIFO non-empty & !control_start. mem_wr_data is the FIFO head.
  - Pop when mem_wr_en & mem_wr_ready. On pop: mem_wr_addr<=mem_wr_addr+1 and inst_count increments unless it is saturated.
  - Address is modulo 2^ADDR_WIDTH. A pop at address 2^ADDR_WIDTH-1 wraps to 0 and sets addr_wrap<=1.
- Latency: completing strobe at edge N gives mem_wr_en=1 from cycle N+1 (FIFO registered). With ready tied high, sustained throughput is 1 instruction/cycle.
- control_start=1 at an edge:
  - clears valids, flushes the FIFO, and sets mem_wr_addr=0 and inst_count=0;
  - strobes in that cycle are ignored;
  - overflow and addr_wrap are kept; only rst clears them.
  - Deasserting it starts a fresh program at address 0.
- rst mid-operation drops staged and buffered instructions immediately. rst has priority over control_start.
- WORDS_PER_INST=1: every strobe completes an instruction.

Optional Feature:
- Macro REGSTRB_DUP_ERR_EN.
- Defined: adds output port dup_err (1 bit, sticky, reset 0).
  - Set when a strobe hits a word whose valid bit is already 1 and the cycle does not complete the instruction.
  - The partial instruction is then discarded (all valids cleared) instead of being overwritten.
  - Cleared only by rst.
- Undefined: no dup_err port; the latest-wins overwrite described above applies.

Test Plan:
- Defaults, ready=1: strobe word0=0x11111111, then 2 cycles later word1=0x22222222 -> one cycle after the second strobe, mem_wr_en=1, addr=0, data=0x2222222211111111. Next pair goes to addr=1; inst_count=2.
- Both strobes in the same cycle with 0xA/0xB, then word_value changed next cycle -> data=0x0000000B0000000A at addr 0 (values latched).
- mem_wr_ready=0; complete 5 instructions -> first 4 are buffered and the 5th is dropped with overflow=1. Release ready -> 4 writes at addr 0..3 with original data; inst_count=4.
- ADDR_WIDTH=2: 5 instructions -> addresses 0,1,2,3,0; addr_wrap=1 after the 4th pop; inst_count saturates at 4.
- Word0 strobed, then control_start=1 for 1 cycle, then word1 strobed -> no write. A following full pair writes addr 0. Pulse control_start while the FIFO holds 2 entries -> FIFO empty, mem_wr_en=0 next cycle.
- REGSTRB_DUP_ERR_EN: word0 strobed twice, then word1 -> dup_err=1 and no write. A fresh pair writes normally at addr 0.
